// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N requesters, with bounded bursts.
// Define FIFO_WRITE_ARB_STATS_EN to add per-requester 16-bit write counters (wr_count).
module fifo_write_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N-1:0]      req,
  input  logic [N*DW-1:0]   data_in,
  input  logic              fifo_full,
  output logic [N-1:0]      grant,
  output logic              fifo_wn,
  output logic [DW-1:0]     fifo_datain,
  output logic              busy
`ifdef FIFO_WRITE_ARB_STATS_EN
  ,
  output logic [N*16-1:0]   wr_count
`endif
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e        state_q;
  logic [IW-1:0] gid_q;
  logic [IW-1:0] rr_ptr_q;
  logic [3:0]    burst_cnt_q;

  logic [IW-1:0] pick;
  logic [IW-1:0] scan_idx;
  logic          found;
  logic          wr_fire;
  logic          last_word;
  logic [IW-1:0] next_rr;

  // First pending requester at or after rr_ptr, wrapping modulo N.
  always_comb begin
    pick     = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      scan_idx = IW'((32'(rr_ptr_q) + k) % N);
      if (!found && req[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
  end

  always_comb begin
    busy        = (state_q == StGrant);
    grant       = '0;
    fifo_datain = '0;
    if (busy) begin
      grant[gid_q] = 1'b1;
      fifo_datain  = data_in[32'(gid_q)*DW +: DW];
    end
    wr_fire   = busy && req[gid_q] && !fifo_full;
    fifo_wn   = wr_fire;
    last_word = (burst_cnt_q == 4'(MAX_BURST - 1));
    next_rr   = (gid_q == IW'(N - 1)) ? '0 : gid_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      gid_q       <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (found) begin
            gid_q       <= pick;
            burst_cnt_q <= '0;
            state_q     <= StGrant;
          end
        end
        StGrant: begin
          if (wr_fire) burst_cnt_q <= burst_cnt_q + 4'd1;
          // A stalled grant holds indefinitely; only a dropped req or a full burst releases it.
          if (!req[gid_q] || (wr_fire && last_word)) begin
            state_q  <= StIdle;
            rr_ptr_q <= next_rr;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef FIFO_WRITE_ARB_STATS_EN
  logic [15:0] cnt_q [N];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N; i++) cnt_q[i] <= '0;
    end else if (wr_fire) begin
      cnt_q[gid_q] <= cnt_q[gid_q] + 16'd1;
    end
  end

  always_comb begin
    wr_count = '0;
    for (int unsigned i = 0; i < N; i++) wr_count[i*16 +: 16] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: vector table, directed corner cases, random vs model.
module tb_fifo_write_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*DW-1:0] data_in;
  logic            fifo_full;
  logic [N-1:0]    grant;
  logic            fifo_wn;
  logic [DW-1:0]   fifo_datain;
  logic            busy;
`ifdef FIFO_WRITE_ARB_STATS_EN
  logic [N*16-1:0] wr_count;
`endif

  always #5 clock = ~clock;

  fifo_write_arbiter #(.N(N), .DW(DW), .MAX_BURST(MB)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .data_in     (data_in),
    .fifo_full   (fifo_full),
    .grant       (grant),
    .fifo_wn     (fifo_wn),
    .fifo_datain (fifo_datain),
    .busy        (busy)
`ifdef FIFO_WRITE_ARB_STATS_EN
    ,
    .wr_count    (wr_count)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the port, words written this grant, where the next scan starts.
  int m_owner;
  int m_words;
  int m_ptr;
  int m_cnt [N];

  logic [N-1:0] last_grant;
  logic         last_wn;
  logic         last_busy;

  typedef struct {
    logic [N-1:0]  req;
    logic          full;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [N-1:0]  g;
    logic          wn;
    logic          bsy;
    logic [DW-1:0] dout;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  function automatic logic exp_wn();
    return (m_owner >= 0) && req[m_owner] && !fifo_full;
  endfunction

  function automatic logic [DW-1:0] exp_data();
    if (m_owner < 0) return '0;
    return data_in[m_owner*DW +: DW];
  endfunction

  task automatic check_model();
    check("grant", 64'(grant), 64'(exp_grant()));
    check("fifo_wn", 64'(fifo_wn), 64'(exp_wn()));
    check("busy", 64'(busy), 64'(m_owner >= 0));
    check("fifo_datain", 64'(fifo_datain), 64'(exp_data()));
`ifdef FIFO_WRITE_ARB_STATS_EN
    for (int i = 0; i < N; i++) check("wr_count", 64'(wr_count[i*16 +: 16]), 64'(m_cnt[i]));
`endif
  endtask

  task automatic model_edge();
    bit wrote;
    bit hit;
    if (m_owner < 0) begin
      hit = 0;
      for (int k = 0; k < N; k++) begin
        if (!hit && req[(m_ptr + k) % N]) begin
          hit     = 1;
          m_owner = (m_ptr + k) % N;
          m_words = 0;
        end
      end
    end else begin
      wrote = req[m_owner] && !fifo_full;
      if (wrote) begin
        m_words++;
        m_cnt[m_owner] = (m_cnt[m_owner] + 1) % 65536;
      end
      if (!req[m_owner] || (wrote && m_words == MB)) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  endtask

  // Entered at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic step();
    #3;
    last_grant = grant;
    last_wn    = fifo_wn;
    last_busy  = busy;
    check_model();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    req       = '0;
    fifo_full = 1'b0;
    data_in   = '0;
    @(posedge clock);
    #1;
    m_owner = -1;
    m_words = 0;
    m_ptr   = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_wn", 64'(fifo_wn), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_datain", 64'(fifo_datain), 64'd0);
    reset = 1'b1;
  endtask

  initial begin
    int           order [$];
    logic [6:0]   wn_hist;
    logic [6:0]   bsy_hist;
    logic [3:0]   wn4;
    logic [3:0]   bsy4;
    logic         prev_busy;

    // Single requester writes 100 then 150, drops; next arbitration starts at requester 1.
    tbl[0] = '{4'b0001, 1'b0, 32'd100, 32'd0, 4'b0000, 1'b0, 1'b0, 32'd0};
    tbl[1] = '{4'b0001, 1'b0, 32'd100, 32'd0, 4'b0001, 1'b1, 1'b1, 32'd100};
    tbl[2] = '{4'b0001, 1'b0, 32'd150, 32'd0, 4'b0001, 1'b1, 1'b1, 32'd150};
    tbl[3] = '{4'b0000, 1'b0, 32'd150, 32'd0, 4'b0001, 1'b0, 1'b1, 32'd150};
    tbl[4] = '{4'b0000, 1'b0, 32'd0,   32'd0, 4'b0000, 1'b0, 1'b0, 32'd0};
    tbl[5] = '{4'b0011, 1'b0, 32'd1,   32'd7, 4'b0000, 1'b0, 1'b0, 32'd0};
    tbl[6] = '{4'b0011, 1'b0, 32'd1,   32'd7, 4'b0010, 1'b1, 1'b1, 32'd7};
    tbl[7] = '{4'b0000, 1'b0, 32'd1,   32'd7, 4'b0010, 1'b0, 1'b1, 32'd7};
    tbl[8] = '{4'b0000, 1'b0, 32'd1,   32'd7, 4'b0000, 1'b0, 1'b0, 32'd0};

    do_reset();
    for (int v = 0; v < 9; v++) begin
      req            = tbl[v].req;
      fifo_full      = tbl[v].full;
      data_in        = '0;
      data_in[31:0]  = tbl[v].d0;
      data_in[63:32] = tbl[v].d1;
      #3;
      check($sformatf("vec%0d_grant", v), 64'(grant), 64'(tbl[v].g));
      check($sformatf("vec%0d_wn", v), 64'(fifo_wn), 64'(tbl[v].wn));
      check($sformatf("vec%0d_busy", v), 64'(busy), 64'(tbl[v].bsy));
      check($sformatf("vec%0d_datain", v), 64'(fifo_datain), 64'(tbl[v].dout));
      model_edge();
      @(posedge clock);
      #1;
    end

    // Burst limit: requester 1 held; 4 writes, one bubble, then granted again.
    do_reset();
    req = 4'b0010;
    data_in[63:32] = 32'h55;
    for (int c = 0; c < 7; c++) begin
      step();
      wn_hist[c]  = last_wn;
      bsy_hist[c] = last_busy;
    end
    check("burst_wn_pattern", 64'(wn_hist), 64'(7'b1011110));
    check("burst_busy_pattern", 64'(bsy_hist), 64'(7'b1011110));
    check("burst_regrant", 64'(last_grant), 64'(4'b0010));

    // Round-robin fairness over two full rounds.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < N; i++) data_in[i*DW +: DW] = 32'(i * 10);
    prev_busy = 1'b0;
    for (int c = 0; c < 41; c++) begin
      step();
      if (last_busy && !prev_busy) begin
        for (int i = 0; i < N; i++) if (last_grant[i]) order.push_back(i);
      end
      prev_busy = last_busy;
    end
    check("rr_grant_count", 64'(order.size()), 64'd8);
    if (order.size() >= 5) begin
      check("rr_order0", 64'(order[0]), 64'd0);
      check("rr_order1", 64'(order[1]), 64'd1);
      check("rr_order2", 64'(order[2]), 64'd2);
      check("rr_order3", 64'(order[3]), 64'd3);
      check("rr_order4", 64'(order[4]), 64'd0);
    end
`ifdef FIFO_WRITE_ARB_STATS_EN
    for (int i = 0; i < N; i++) check("stats_eight", 64'(wr_count[i*16 +: 16]), 64'd8);
`endif

    // Full stall after one write to requester 2.
    do_reset();
    req = 4'b0100;
    data_in[95:64] = 32'hABCD;
    step();
    step();
    check("stall_first_write", 64'(last_wn), 64'd1);
    fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("stall_wn", 64'(last_wn), 64'd0);
      check("stall_grant", 64'(last_grant), 64'(4'b0100));
    end
    fifo_full = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      wn4[c]  = last_wn;
      bsy4[c] = last_busy;
    end
    check("stall_resume_wn", 64'(wn4), 64'(4'b0111));
    check("stall_resume_busy", 64'(bsy4), 64'(4'b0111));

    // Asynchronous reset mid-burst, then restart from requester 0.
    do_reset();
    req = 4'b1111;
    step();
    step();
    step();
    check("pre_areset_busy", 64'(busy), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("areset_grant", 64'(grant), 64'd0);
    check("areset_wn", 64'(fifo_wn), 64'd0);
    check("areset_busy", 64'(busy), 64'd0);
    check("areset_datain", 64'(fifo_datain), 64'd0);
    @(posedge clock);
    #1;
    m_owner = -1;
    m_words = 0;
    m_ptr   = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    reset = 1'b1;
    step();
    step();
    check("areset_restart", 64'(last_grant), 64'(4'b0001));

    // Random traffic against the model, with back-pressure.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        req[i]              = ($urandom_range(0, 9) < 7);
        data_in[i*DW +: DW] = $urandom;
      end
      fifo_full = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
